// File: rtl/reg_readout_if.sv
// Bus bundle for the register readout block: live CPU registers and request in,
// byte stream with valid/ready handshake and status flags out.
interface reg_readout_if #(
    parameter int WIDTH = 8
);
    logic                 CE;
    logic                 REQ;
    logic [WIDTH-1:0]     A_IN;
    logic [WIDTH-1:0]     X_IN;
    logic [WIDTH-1:0]     Y_IN;
    logic [WIDTH-1:0]     SP_IN;
    logic [WIDTH-1:0]     P_IN;
    logic [2*WIDTH-1:0]   PC_IN;
    logic                 READY;
    logic [WIDTH-1:0]     DOUT;
    logic                 DVALID;
    logic                 BUSY;
    logic                 DONE;

    modport master (
        output CE, REQ, A_IN, X_IN, Y_IN, SP_IN, P_IN, PC_IN, READY,
        input  DOUT, DVALID, BUSY, DONE
    );

    modport slave (
        input  CE, REQ, A_IN, X_IN, Y_IN, SP_IN, P_IN, PC_IN, READY,
        output DOUT, DVALID, BUSY, DONE
    );
endinterface

// File: rtl/reg_readout.sv
// Snapshots the CPU registers on request and streams them out one byte per
// accepted handshake: A, X, Y, SP, P, PC low, PC high, then a one-cycle DONE.
module reg_readout #(
    parameter int WIDTH = 8
) (
    input logic          CLK,
    input logic          RST,
    reg_readout_if.slave bus
);
    localparam int         NUM_BYTES  = 7;
    localparam logic [2:0] LAST_INDEX = 3'd6;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       index_reg, index_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             dvalid_reg, dvalid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             capture;

    logic [WIDTH-1:0] live [NUM_BYTES];
    logic [WIDTH-1:0] snap_reg [NUM_BYTES];

    assign live[0] = bus.A_IN;
    assign live[1] = bus.X_IN;
    assign live[2] = bus.Y_IN;
    assign live[3] = bus.SP_IN;
    assign live[4] = bus.P_IN;
    assign live[5] = bus.PC_IN[WIDTH-1:0];
    assign live[6] = bus.PC_IN[2*WIDTH-1:WIDTH];

    // Snapshot needs no reset: it is only ever read after a capture.
    always_ff @(posedge CLK) begin
        if (!RST && bus.CE && capture) begin
            snap_reg <= live;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            index_reg  <= '0;
            dout_reg   <= '0;
            dvalid_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else if (bus.CE) begin
            state_reg  <= state_next;
            index_reg  <= index_next;
            dout_reg   <= dout_next;
            dvalid_reg <= dvalid_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        index_next  = index_reg;
        dout_next   = dout_reg;
        dvalid_next = dvalid_reg;
        done_next   = 1'b0;
        capture     = 1'b0;
        case (state_reg)
            IDLE: begin
                // First byte comes straight from the live inputs so it appears
                // on the capture edge itself.
                if (bus.REQ) begin
                    capture     = 1'b1;
                    state_next  = SEND;
                    index_next  = '0;
                    dout_next   = live[0];
                    dvalid_next = 1'b1;
                end
            end
            SEND: begin
                if (bus.READY) begin
                    if (index_reg == LAST_INDEX) begin
                        state_next  = DONE;
                        dout_next   = '0;
                        dvalid_next = 1'b0;
                        done_next   = 1'b1;
                    end else begin
                        index_next = index_reg + 3'd1;
                        dout_next  = snap_reg[index_reg + 3'd1];
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    assign bus.DOUT   = dout_reg;
    assign bus.DVALID = dvalid_reg;
    assign bus.BUSY   = busy_reg;
    assign bus.DONE   = done_reg;
endmodule

// File: tb/tb_reg_readout.sv
// Directed bench for reg_readout: a queue-based model of the readout is checked
// against the DUT every cycle, and literal byte sequences pin the model.
module tb_reg_readout;
    localparam int WIDTH = 8;

    logic CLK = 1'b0;
    logic RST;

    reg_readout_if #(.WIDTH(WIDTH)) bus ();

    reg_readout #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    logic cmp_en = 1'b0;

    // Model: the bytes still owed to the receiver, and whether DONE is showing.
    logic [7:0] m_q[$];
    logic [7:0] m_log[$];
    logic       m_done = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] basic_seq [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            m_q.delete();
            m_done = 1'b0;
        end else if (bus.CE) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_q.size() > 0) begin
                if (bus.READY) begin
                    m_log.push_back(m_q.pop_front());
                    if (m_q.size() == 0) m_done = 1'b1;
                end
            end else if (bus.REQ) begin
                m_q.push_back(bus.A_IN);
                m_q.push_back(bus.X_IN);
                m_q.push_back(bus.Y_IN);
                m_q.push_back(bus.SP_IN);
                m_q.push_back(bus.P_IN);
                m_q.push_back(bus.PC_IN[7:0]);
                m_q.push_back(bus.PC_IN[15:8]);
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("dout", {24'h0, bus.DOUT}, {24'h0, (m_q.size() > 0) ? m_q[0] : 8'h00});
            chk("dvalid", {31'h0, bus.DVALID}, {31'h0, m_q.size() > 0});
            chk("busy", {31'h0, bus.BUSY}, {31'h0, (m_q.size() > 0) || m_done});
            chk("done", {31'h0, bus.DONE}, {31'h0, m_done});
            if (bus.BUSY) busy_cnt++;
            if (bus.DONE) done_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_basic_regs();
        bus.A_IN  = 8'h11;
        bus.X_IN  = 8'h22;
        bus.Y_IN  = 8'h33;
        bus.SP_IN = 8'hFD;
        bus.P_IN  = 8'h24;
        bus.PC_IN = 16'hC0DE;
    endtask

    task automatic pulse_req();
        bus.REQ = 1'b1;
        tick();
        bus.REQ = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (!bus.DONE && n < limit) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, {31'h0, bus.DONE}, 32'h1);
        tick();
    endtask

    task automatic wait_dout(input string name, input logic [7:0] val, input int limit);
        int n = 0;
        while (!(bus.DVALID && bus.DOUT == val) && n < limit) begin
            tick();
            n++;
        end
        chk({name, "_reach"}, {24'h0, bus.DOUT}, {24'h0, val});
    endtask

    task automatic load_basic_exp(input int times);
        exp_q.delete();
        for (int t = 0; t < times; t++)
            for (int i = 0; i < 7; i++) exp_q.push_back(basic_seq[i]);
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, m_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < m_log.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), {24'h0, m_log[i]}, {24'h0, exp_q[i]});
    endtask

    initial begin
        int n;
        basic_seq = '{8'h11, 8'h22, 8'h33, 8'hFD, 8'h24, 8'hDE, 8'hC0};
        RST       = 1'b1;
        bus.CE    = 1'b1;
        bus.REQ   = 1'b0;
        bus.READY = 1'b1;
        set_basic_regs();
        tick(2);
        cmp_en = 1'b1;
        chk("reset_dout", {24'h0, bus.DOUT}, 32'h0);
        chk("reset_dvalid", {31'h0, bus.DVALID}, 32'h0);
        chk("reset_busy", {31'h0, bus.BUSY}, 32'h0);
        chk("reset_done", {31'h0, bus.DONE}, 32'h0);
        RST = 1'b0;
        tick(2);

        // Basic readout
        m_log.delete();
        busy_cnt = 0;
        done_cnt = 0;
        pulse_req();
        chk("basic_first", {24'h0, bus.DOUT}, 32'h11);
        wait_done("basic", 20);
        load_basic_exp(1);
        chk_log("basic");
        chk("basic_busy_cycles", busy_cnt, 8);
        chk("basic_done_pulses", done_cnt, 1);
        tick(2);

        // Backpressure while 0x33 is presented
        m_log.delete();
        pulse_req();
        wait_dout("bp", 8'h33, 10);
        bus.READY = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_hold", {24'h0, bus.DOUT}, 32'h33);
            chk("bp_dvalid", {31'h0, bus.DVALID}, 32'h1);
        end
        bus.READY = 1'b1;
        tick();
        chk("bp_resume", {24'h0, bus.DOUT}, 32'hFD);
        wait_done("bp", 20);
        chk_log("bp");
        tick(2);

        // Inputs change right after capture
        m_log.delete();
        pulse_req();
        bus.A_IN  = 8'h99;
        bus.PC_IN = 16'h1234;
        wait_done("snap", 20);
        chk_log("snap");
        set_basic_regs();
        tick(2);

        // Clock enable low mid-readout
        m_log.delete();
        pulse_req();
        tick(2);
        bus.CE = 1'b0;
        repeat (2) begin
            tick();
            chk("ce_hold", {24'h0, bus.DOUT}, 32'h33);
        end
        bus.CE = 1'b1;
        tick();
        chk("ce_resume", {24'h0, bus.DOUT}, 32'hFD);
        wait_done("ce", 20);
        chk_log("ce");
        tick(2);

        // Reset while 0xFD is presented
        m_log.delete();
        done_cnt = 0;
        pulse_req();
        wait_dout("rst", 8'hFD, 10);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_dvalid", {31'h0, bus.DVALID}, 32'h0);
        chk("rst_dout", {24'h0, bus.DOUT}, 32'h0);
        chk("rst_busy", {31'h0, bus.BUSY}, 32'h0);
        chk("rst_done", {31'h0, bus.DONE}, 32'h0);
        exp_q = '{8'h11, 8'h22, 8'h33};
        chk_log("rst_partial");
        tick(3);
        chk("rst_no_done", done_cnt, 0);
        m_log.delete();
        pulse_req();
        chk("rst_restart_first", {24'h0, bus.DOUT}, 32'h11);
        wait_done("rst_restart", 20);
        load_basic_exp(1);
        chk_log("rst_restart");
        tick(2);

        // REQ during SEND is ignored and not queued
        m_log.delete();
        done_cnt = 0;
        pulse_req();
        tick();
        pulse_req();
        wait_done("busyreq", 20);
        chk_log("busyreq");
        tick(4);
        chk("busyreq_idle", {31'h0, bus.BUSY}, 32'h0);
        chk("busyreq_done_pulses", done_cnt, 1);

        // REQ held high: back-to-back readouts
        m_log.delete();
        bus.REQ = 1'b1;
        tick();
        n = 0;
        while (!bus.DONE && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_done_seen", {31'h0, bus.DONE}, 32'h1);
        n = 0;
        while (!bus.DVALID && n < 10) begin
            tick();
            n++;
        end
        chk("b2b_gap", n, 2);
        bus.REQ = 1'b0;
        wait_done("b2b", 20);
        load_basic_exp(2);
        chk_log("b2b");
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
